// File: rtl/sauria_cfg_regbank_pkg.sv
// Shared types, section constants and helpers for the SAURIA config register bank.
package sauria_cfg_pkg;

    typedef enum logic [1:0] {IDLE, PENDING, COMMIT, RUN} cfg_state_t;

    localparam int SEC_CON = 0;
    localparam int SEC_ACT = 1;
    localparam int SEC_WEI = 2;
    localparam int SEC_OUT = 3;

    localparam int DEF_N_SEC = 4;
    localparam int DEF_REG_W = 32;

    localparam int CON_BITS = 256;
    localparam int ACT_BITS = 256;
    localparam int WEI_BITS = 256;
    localparam int OUT_BITS = 256;

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

    // index 0 (CON) sits in the least significant word
    localparam logic [DEF_N_SEC-1:0][31:0] DEF_SEC_REGS = {
        32'(ceil_div(OUT_BITS, DEF_REG_W)),
        32'(ceil_div(WEI_BITS, DEF_REG_W)),
        32'(ceil_div(ACT_BITS, DEF_REG_W)),
        32'(ceil_div(CON_BITS, DEF_REG_W))
    };

    localparam int PAR_W = 64;

    function automatic logic even_par(input logic [PAR_W-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/sauria_cfg_regbank_if.sv
// Config-bus and core-control signals between the CDC side and the register bank.
interface sauria_cfg_regbank_if #(
    parameter int ADDR_W = 6,
    parameter int REG_W  = 32
);
    logic              i_cfg_req;
    logic              i_cfg_we;
    logic [ADDR_W-1:0] i_cfg_addr;
    logic [REG_W-1:0]  i_cfg_wdata;
    logic              o_cfg_gnt;
    logic              o_cfg_rvalid;
    logic [REG_W-1:0]  o_cfg_rdata;
    logic              o_cfg_err;
    logic              i_start;
    logic              i_core_idle;
    logic              i_core_done;
    logic              o_core_start;
    logic              o_busy;

    modport master (
        output i_cfg_req, i_cfg_we, i_cfg_addr, i_cfg_wdata,
        output i_start, i_core_idle, i_core_done,
        input  o_cfg_gnt, o_cfg_rvalid, o_cfg_rdata, o_cfg_err,
        input  o_core_start, o_busy
    );

    modport slave (
        input  i_cfg_req, i_cfg_we, i_cfg_addr, i_cfg_wdata,
        input  i_start, i_core_idle, i_core_done,
        output o_cfg_gnt, o_cfg_rvalid, o_cfg_rdata, o_cfg_err,
        output o_core_start, o_busy
    );
endinterface

// File: rtl/sauria_cfg_reg_pair.sv
// One shadow/active register pair; SAURIA_CFG_PARITY_EN adds a stored even-parity bit.
module sauria_cfg_reg_pair
    import sauria_cfg_pkg::*;
#(
    parameter int REG_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic             commit,
    input  logic [REG_W-1:0] wdata,
`ifdef SAURIA_CFG_PARITY_EN
    input  logic             par_inject,
`endif
    output logic [REG_W-1:0] shadow,
    output logic [REG_W-1:0] active,
    output logic             shadow_perr,
    output logic             active_perr
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow <= '0;
            active <= '0;
        end else begin
            if (we)
                shadow <= wdata;
            if (commit)
                active <= shadow;
        end
    end

`ifdef SAURIA_CFG_PARITY_EN
    logic sh_par;
    logic ac_par;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_par <= 1'b0;
            ac_par <= 1'b0;
        end else begin
            if (we)
                sh_par <= even_par(PAR_W'(wdata)) ^ par_inject;
            if (commit)
                ac_par <= sh_par;
        end
    end

    assign shadow_perr = even_par(PAR_W'(shadow)) != sh_par;
    assign active_perr = even_par(PAR_W'(active)) != ac_par;
`else
    assign shadow_perr = 1'b0;
    assign active_perr = 1'b0;
`endif

endmodule

// File: rtl/sauria_cfg_regbank.sv
// Double-buffered SAURIA configuration bank: shadow writes, commit-on-idle, active fan-out.
// Optional parity storage and check under SAURIA_CFG_PARITY_EN.
module sauria_cfg_regbank
    import sauria_cfg_pkg::*;
#(
    parameter int REG_W     = 32,
    parameter int N_SEC     = 4,
    parameter int MAX_REGS  = 8,
    parameter logic [N_SEC-1:0][31:0] SEC_REGS = DEF_SEC_REGS,
    parameter int SEC_W     = $clog2(N_SEC),
    parameter int REG_IDX_W = $clog2(MAX_REGS),
    parameter int ADDR_W    = 1 + SEC_W + REG_IDX_W
) (
    input  logic i_clk,
    input  logic i_rst,
`ifdef SAURIA_CFG_PARITY_EN
    input  logic i_par_inject,
`endif
    sauria_cfg_regbank_if.slave cfg,
    output logic [N_SEC*MAX_REGS*REG_W-1:0] o_active_cfg
);

    localparam int N_SLOT = N_SEC * MAX_REGS;
    localparam int SLOT_W = (N_SLOT > 1) ? $clog2(N_SLOT) : 1;

    cfg_state_t state;
    cfg_state_t state_nx;

    logic                 bank;
    logic [SEC_W-1:0]     sec;
    logic [REG_IDX_W-1:0] idx;
    logic                 in_range;
    logic [SLOT_W-1:0]    slot;

    logic gnt;
    logic stall;
    logic wr;
    logic rd;
    logic wr_err;
    logic sh_we;
    logic commit;

    logic [REG_W-1:0]  shadow_q [N_SLOT];
    logic [REG_W-1:0]  active_q [N_SLOT];
    logic [N_SLOT-1:0] shadow_perr;
    logic [N_SLOT-1:0] active_perr;

    logic [REG_W-1:0] rd_val;
    logic             perr;

    logic             rvalid;
    logic [REG_W-1:0] rdata;
    logic             rd_err;
    logic             core_start;

    assign bank = cfg.i_cfg_addr[ADDR_W-1];
    assign sec  = cfg.i_cfg_addr[REG_IDX_W +: SEC_W];
    assign idx  = cfg.i_cfg_addr[REG_IDX_W-1:0];

    always_comb begin
        in_range = 1'b0;
        slot     = '0;
        if (int'(sec) < N_SEC) begin
            if (int'(idx) < int'(SEC_REGS[sec])) begin
                in_range = 1'b1;
                slot     = SLOT_W'(int'(sec) * MAX_REGS + int'(idx));
            end
        end
    end

    // only shadow writes collide with the copy; reads and active-bank writes proceed
    assign stall  = (state == COMMIT) && cfg.i_cfg_we && !bank;
    assign gnt    = cfg.i_cfg_req && !stall;
    assign wr     = gnt && cfg.i_cfg_we;
    assign rd     = gnt && !cfg.i_cfg_we;
    assign wr_err = wr && (bank || !in_range);
    assign sh_we  = wr && !bank && in_range;
    assign commit = (state == COMMIT);

    for (genvar s = 0; s < N_SEC; s++) begin : g_sec
        for (genvar r = 0; r < MAX_REGS; r++) begin : g_reg
            localparam int K = s * MAX_REGS + r;
            if (r < int'(SEC_REGS[s])) begin : g_used
                sauria_cfg_reg_pair #(
                    .REG_W (REG_W)
                ) u_pair (
                    .clk         (i_clk),
                    .rst         (i_rst),
                    .we          (sh_we && (slot == SLOT_W'(K))),
                    .commit      (commit),
                    .wdata       (cfg.i_cfg_wdata),
`ifdef SAURIA_CFG_PARITY_EN
                    .par_inject  (i_par_inject),
`endif
                    .shadow      (shadow_q[K]),
                    .active      (active_q[K]),
                    .shadow_perr (shadow_perr[K]),
                    .active_perr (active_perr[K])
                );
            end else begin : g_unused
                assign shadow_q[K]    = '0;
                assign active_q[K]    = '0;
                assign shadow_perr[K] = 1'b0;
                assign active_perr[K] = 1'b0;
            end
            assign o_active_cfg[K*REG_W +: REG_W] = active_q[K];
        end
    end

    assign rd_val = bank ? active_q[slot] : shadow_q[slot];
    assign perr   = bank ? active_perr[slot] : shadow_perr[slot];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rvalid <= 1'b0;
            rdata  <= '0;
            rd_err <= 1'b0;
        end else begin
            rvalid <= rd;
            if (rd) begin
                rdata  <= in_range ? rd_val : '0;
                rd_err <= !in_range || perr;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state      <= IDLE;
            core_start <= 1'b0;
        end else begin
            state      <= state_nx;
            core_start <= (state == COMMIT);
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (cfg.i_start)     state_nx = PENDING;
            PENDING: if (cfg.i_core_idle) state_nx = COMMIT;
            COMMIT:                       state_nx = RUN;
            RUN:     if (cfg.i_core_done) state_nx = IDLE;
            default:                      state_nx = IDLE;
        endcase
    end

    assign cfg.o_cfg_gnt    = gnt;
    assign cfg.o_cfg_rvalid = rvalid;
    assign cfg.o_cfg_rdata  = rdata;
    assign cfg.o_cfg_err    = wr_err || (rvalid && rd_err);
    assign cfg.o_core_start = core_start;
    assign cfg.o_busy       = (state != IDLE);

endmodule

// File: tb/tb_sauria_cfg_regbank.sv
// Bench for sauria_cfg_regbank: array-based model checked every cycle plus directed literals.
module tb_sauria_cfg_regbank;
    import sauria_cfg_pkg::*;

    localparam int RW = 32;
    localparam int AW = 6;
    localparam int NS = 4;
    localparam int MR = 8;
    localparam int SR [NS] = '{8, 8, 8, 5};

    logic clk = 1'b0;
    logic rst = 1'b1;
`ifdef SAURIA_CFG_PARITY_EN
    logic par_inject = 1'b0;
`endif
    logic [NS*MR*RW-1:0] active_cfg;

    int checks = 0;
    int errors = 0;
    bit cmp_on = 1'b0;

    sauria_cfg_regbank_if #(.ADDR_W(AW), .REG_W(RW)) bus ();

    sauria_cfg_regbank #(
        .REG_W    (RW),
        .N_SEC    (NS),
        .MAX_REGS (MR),
        .SEC_REGS ({32'd5, 32'd8, 32'd8, 32'd8})
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
`ifdef SAURIA_CFG_PARITY_EN
        .i_par_inject (par_inject),
`endif
        .cfg          (bus),
        .o_active_cfg (active_cfg)
    );

    always #5 clk = ~clk;

    // model: plain arrays, a phase number and a pending-read record
    int        m_phase;
    logic [31:0] m_sh [NS*MR];
    logic [31:0] m_ac [NS*MR];
    bit        m_shb [NS*MR];
    bit        m_acb [NS*MR];
    bit        m_rv;
    logic [31:0] m_rd;
    bit        m_rerr;
    bit        m_start;

    function automatic int kof(input logic [AW-1:0] a);
        return int'(a[4:3]) * MR + int'(a[2:0]);
    endfunction

    function automatic bit ok(input logic [AW-1:0] a);
        return int'(a[2:0]) < SR[a[4:3]];
    endfunction

    function automatic logic [AW-1:0] A(input int b, input int s, input int r);
        return {b[0], s[1:0], r[2:0]};
    endfunction

    function automatic bit e_gnt();
        bit sh_wr;
        sh_wr = bus.i_cfg_we && !bus.i_cfg_addr[5];
        return bus.i_cfg_req && !(sh_wr && m_phase == 2);
    endfunction

    function automatic bit e_err();
        bit werr;
        werr = e_gnt() && bus.i_cfg_we && (bus.i_cfg_addr[5] || !ok(bus.i_cfg_addr));
        return werr || (m_rv && m_rerr);
    endfunction

    function automatic logic [NS*MR*RW-1:0] e_active();
        logic [NS*MR*RW-1:0] v;
        v = '0;
        for (int k = 0; k < NS*MR; k++)
            v[k*RW +: RW] = m_ac[k];
        return v;
    endfunction

    function automatic logic [31:0] act_word(input int s, input int r);
        return active_cfg[(s*MR+r)*RW +: RW];
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase <= 0;
            m_rv    <= 1'b0;
            m_rd    <= '0;
            m_rerr  <= 1'b0;
            m_start <= 1'b0;
            for (int k = 0; k < NS*MR; k++) begin
                m_sh[k]  <= '0;
                m_ac[k]  <= '0;
                m_shb[k] <= 1'b0;
                m_acb[k] <= 1'b0;
            end
        end else begin
            m_start <= (m_phase == 2);
            if (m_phase == 0 && bus.i_start) m_phase <= 1;
            if (m_phase == 1 && bus.i_core_idle) m_phase <= 2;
            if (m_phase == 3 && bus.i_core_done) m_phase <= 0;
            if (m_phase == 2) begin
                m_phase <= 3;
                for (int k = 0; k < NS*MR; k++) begin
                    m_ac[k]  <= m_sh[k];
                    m_acb[k] <= m_shb[k];
                end
            end
            if (e_gnt() && bus.i_cfg_we && !bus.i_cfg_addr[5] && ok(bus.i_cfg_addr)) begin
                m_sh[kof(bus.i_cfg_addr)] <= bus.i_cfg_wdata;
`ifdef SAURIA_CFG_PARITY_EN
                m_shb[kof(bus.i_cfg_addr)] <= par_inject;
`endif
            end
            m_rv <= e_gnt() && !bus.i_cfg_we;
            if (e_gnt() && !bus.i_cfg_we) begin
                if (!ok(bus.i_cfg_addr)) begin
                    m_rd   <= '0;
                    m_rerr <= 1'b1;
                end else if (bus.i_cfg_addr[5]) begin
                    m_rd   <= m_ac[kof(bus.i_cfg_addr)];
                    m_rerr <= m_acb[kof(bus.i_cfg_addr)];
                end else begin
                    m_rd   <= m_sh[kof(bus.i_cfg_addr)];
                    m_rerr <= m_shb[kof(bus.i_cfg_addr)];
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && cmp_on) begin
            chk("m_gnt", bus.o_cfg_gnt, e_gnt());
            chk("m_rvalid", bus.o_cfg_rvalid, m_rv);
            chk("m_rdata", bus.o_cfg_rdata, m_rd);
            chk("m_err", bus.o_cfg_err, e_err());
            chk("m_busy", bus.o_busy, m_phase != 0);
            chk("m_core_start", bus.o_core_start, m_start);
            checks++;
            if (active_cfg !== e_active()) begin
                errors++;
                $display("FAIL m_active_cfg differs from model at %0t", $time);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit req, input bit we, input logic [AW-1:0] a,
                         input logic [31:0] d);
        bus.i_cfg_req   = req;
        bus.i_cfg_we    = we;
        bus.i_cfg_addr  = a;
        bus.i_cfg_wdata = d;
    endtask

    task automatic bus_off();
        drive(1'b0, 1'b0, '0, '0);
    endtask

    task automatic done_pulse();
        bus.i_core_done = 1'b1;
        tick();
        bus.i_core_done = 1'b0;
    endtask

    initial begin
        int n;
        bus_off();
        bus.i_start     = 1'b0;
        bus.i_core_idle = 1'b0;
        bus.i_core_done = 1'b0;
        tick();
        tick();
        chk("rst_gnt", bus.o_cfg_gnt, 0);
        chk("rst_rvalid", bus.o_cfg_rvalid, 0);
        chk("rst_rdata", bus.o_cfg_rdata, 0);
        chk("rst_err", bus.o_cfg_err, 0);
        chk("rst_busy", bus.o_busy, 0);
        chk("rst_start", bus.o_core_start, 0);
        chk("rst_active", active_cfg == '0, 1);
        rst = 1'b0;
        cmp_on = 1'b1;
        tick();

        // shadow write then read-back, active untouched
        drive(1, 1, A(0, 1, 2), 32'hDEADBEEF);
        #2;
        chk("wr_gnt", bus.o_cfg_gnt, 1);
        chk("wr_err", bus.o_cfg_err, 0);
        tick();
        drive(1, 0, A(0, 1, 2), '0);
        tick();
        bus_off();
        chk("rd_valid", bus.o_cfg_rvalid, 1);
        chk("rd_data", bus.o_cfg_rdata, 32'hDEADBEEF);
        chk("act_pre", act_word(1, 2), 0);
        tick();

        // start and idle together: start pulse three edges later
        bus.i_core_idle = 1'b1;
        bus.i_start     = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!bus.o_core_start && n < 10);
        chk("start_latency", n, 3);
        chk("act_s1r2", act_word(1, 2), 32'hDEADBEEF);
        chk("run_busy", bus.o_busy, 1);
        bus.i_start     = 1'b0;
        bus.i_core_idle = 1'b0;
        repeat (3) tick();
        chk("run_busy_hold", bus.o_busy, 1);
        done_pulse();
        chk("idle_busy", bus.o_busy, 0);
        tick();

        // long PENDING with a write in the middle
        bus.i_start = 1'b1;
        tick();
        bus.i_start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (i == 3) drive(1, 1, A(0, 0, 0), 32'h12345678);
            else bus_off();
            tick();
        end
        bus_off();
        chk("pend_busy", bus.o_busy, 1);
        chk("pend_act", act_word(0, 0), 0);
        // write issued on the edge into COMMIT is copied
        bus.i_core_idle = 1'b1;
        drive(1, 1, A(0, 0, 1), 32'hCAFEF00D);
        tick();
        drive(1, 1, A(0, 0, 2), 32'h00000BAD);
        #2;
        chk("commit_stall", bus.o_cfg_gnt, 0);
        tick();
        chk("pend_start", bus.o_core_start, 1);
        chk("run_gnt", bus.o_cfg_gnt, 1);
        tick();
        bus_off();
        bus.i_core_idle = 1'b0;
        chk("act_s0r0", act_word(0, 0), 32'h12345678);
        chk("act_s0r1", act_word(0, 1), 32'hCAFEF00D);
        chk("act_s0r2", act_word(0, 2), 0);
        drive(1, 0, A(0, 0, 2), '0);
        tick();
        bus_off();
        chk("sh_s0r2", bus.o_cfg_rdata, 32'h00000BAD);
        done_pulse();

        // range and bank errors
        drive(1, 1, A(0, 3, 6), 32'hFFFFFFFF);
        #2;
        chk("oor_wr_err", bus.o_cfg_err, 1);
        tick();
        drive(1, 0, A(0, 3, 6), '0);
        tick();
        bus_off();
        chk("oor_rd_data", bus.o_cfg_rdata, 0);
        chk("oor_rd_err", bus.o_cfg_err, 1);
        drive(1, 1, A(1, 1, 2), 32'h55555555);
        #2;
        chk("act_wr_gnt", bus.o_cfg_gnt, 1);
        chk("act_wr_err", bus.o_cfg_err, 1);
        tick();
        drive(1, 0, A(1, 1, 2), '0);
        tick();
        bus_off();
        chk("act_rd_data", bus.o_cfg_rdata, 32'hDEADBEEF);
        chk("act_rd_err", bus.o_cfg_err, 0);
        drive(1, 1, A(0, 3, 4), 32'hA5A5A5A5);
        tick();
        drive(1, 0, A(0, 3, 4), '0);
        tick();
        drive(1, 0, A(0, 3, 5), '0);
        #2;
        chk("last_rd_data", bus.o_cfg_rdata, 32'hA5A5A5A5);
        chk("last_rd_err", bus.o_cfg_err, 0);
        tick();
        bus_off();
        chk("first_oor_err", bus.o_cfg_err, 1);
        tick();

        // reset in the middle of COMMIT
        bus.i_core_idle = 1'b1;
        bus.i_start     = 1'b1;
        tick();
        bus.i_start = 1'b0;
        tick();
        #1;
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", bus.o_busy, 0);
        chk("mid_rst_start", bus.o_core_start, 0);
        chk("mid_rst_rdata", bus.o_cfg_rdata, 0);
        chk("mid_rst_active", active_cfg == '0, 1);
        tick();
        rst = 1'b0;
        tick();
        drive(1, 0, A(0, 1, 2), '0);
        tick();
        bus_off();
        chk("post_rst_sh", bus.o_cfg_rdata, 0);
        repeat (3) tick();
        chk("post_rst_act", active_cfg == '0, 1);
        chk("post_rst_busy", bus.o_busy, 0);

`ifdef SAURIA_CFG_PARITY_EN
        bus.i_core_idle = 1'b0;
        par_inject = 1'b1;
        drive(1, 1, A(0, 2, 0), 32'h1);
        tick();
        par_inject = 1'b0;
        drive(1, 0, A(0, 2, 0), '0);
        tick();
        bus_off();
        chk("par_bad_data", bus.o_cfg_rdata, 32'h1);
        chk("par_bad_err", bus.o_cfg_err, 1);
        drive(1, 1, A(0, 2, 0), 32'h1);
        tick();
        drive(1, 0, A(0, 2, 0), '0);
        tick();
        bus_off();
        chk("par_ok_err", bus.o_cfg_err, 0);
        tick();
`endif

        cmp_on = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

endmodule
